fpga_clkrst_ctrl: RTL and testbench
===================================

Name: fpga_clkrst_ctrl

Overview:
Clock/reset controller at the top of the FPGA build hosting the RISC-V SoC and the MCS-4 (4004) system/CPU pair.
- Generates the internal power-on reset and the synchronized system reset, which is also exported on RESOUT_N.
- Divides the 50 MHz board clock into the ~735 kHz MCS-4 clock and sequences the MCS-4 reset.
- Synchronizes the external reset-halt strap.

Parameters:
POR_CYCLES, 1024, CLK50 cycles from configuration until por_n rises (legal 2..65535).
MCS4_HALF, 34, CLK50 cycles per MCS-4 clock half-period (default period 68 -> 735.3 kHz; legal 1..255).
MCS4_RES_CYC, 64, MCS-4 clock periods MCS4_RES_N stays low after system reset release (legal 1..255).

Ports:
CLK50  in  1  board clock, 50 MHz; the only clock.
RES_N  in  1  asynchronous active-low external reset.
RESET_HALT_N  in  1  asynchronous strap (GPIO2[10]); low = halt CPU after reset.
MCS4_RES_REQ  in  1  synchronous request from SoC to re-reset the MCS-4 system.
clk  out  1  system clock = CLK50 passthrough; no PLL.
res_sys_n  out  1  synchronized system reset to all SoC logic.
RESOUT_N  out  1  copy of res_sys_n driven off-chip.
halt_req  out  1  synchronized, inverted RESET_HALT_N.
S_MCS4_CLK  out  1  MCS-4 clock.
S_MCS4_RES_N  out  1  MCS-4 active-low reset.

Behaviour:
Power-on reset:
- Registers por_count[15:0] and por_n are not reset by RES_N; their initial values come from FPGA configuration (0 and 0).
- Each CLK50 posedge with por_n=0: por_count increments. When por_count == POR_CYCLES-1, por_n is set to 1 on that edge.
- por_n stays 1 thereafter. por_count stops counting once por_n=1.

System reset:
- arst_n = RES_N & por_n.
- 2-flop synchronizer: asynchronous assertion (clear) on arst_n low, synchronous deassertion.
- res_sys_n rises on the 2nd CLK50 posedge after arst_n goes high. RESOUT_N = res_sys_n.

Halt strap:
- 2-flop synchronizer, reset to 1 by res_sys_n low. halt_req = ~sync output.
- Reset value of halt_req = 0. Latency from a RESET_HALT_N change is 2 cycles.

MCS-4 clock:
- 8-bit div_cnt and clock flop mclk, both cleared while res_sys_n=0; S_MCS4_CLK = mclk, reset value 0.
- On each posedge: if div_cnt == MCS4_HALF-1, then div_cnt <= 0 and mclk toggles; else div_cnt increments.
- Duty cycle is exactly 50%. The first rising edge of mclk occurs MCS4_HALF cycles after res_sys_n rises.

MCS-4 reset:
- 8-bit mres_cnt and flop mres_n; mres_n is cleared while res_sys_n=0. S_MCS4_RES_N = mres_n, reset value 0.
- mres_cnt advances on the CLK50 cycle where mclk toggles 1->0 (end of an MCS-4 period).
- When mres_cnt reaches MCS4_RES_CYC, mres_n <= 1 and counting stops.
- MCS4_RES_REQ=1 on any cycle: mres_n <= 0 and mres_cnt <= 0 on the next edge; the sequence restarts after the request drops.
- A held request keeps the MCS-4 system in reset. A request coinciding with the release edge wins (stays low).
- RES_N asserted mid-sequence: asynchronous clear of all counters and outputs.

Optional Feature:
Macro FPGA_CLKRST_MCS4_CLK_STOP_EN.
- Defined: adds input mcs4_clk_stop (1 bit). While it is 1, a pending 1->0 toggle still occurs, but 0->1 toggles are suppressed and div_cnt holds at 0, so the clock freezes low. On release, the next rising edge follows MCS4_HALF cycles later. The MCS-4 reset counter does not advance while frozen.
- Undefined: the port is absent and the clock free-runs.

Test Plan:
1. Power-on with por_count=0, por_n=0, RES_N=1, POR_CYCLES=16 -> por_n rises at posedge 16; res_sys_n and RESOUT_N rise at posedge 18.
2. After reset, MCS4_HALF=34 -> S_MCS4_CLK first rises 34 cycles after res_sys_n, period 68 cycles, high exactly 34 cycles.
3. MCS4_RES_CYC=64 -> S_MCS4_RES_N rises at the 64th mclk falling edge, 4352 cycles after res_sys_n.
4. MCS4_RES_REQ pulsed 1 cycle after release -> S_MCS4_RES_N low next cycle, high again 64 MCS-4 periods later; a 10-cycle RES_N low pulse mid-run zeroes all outputs asynchronously.
5. RESET_HALT_N driven 0 -> halt_req=1 two cycles later; res_sys_n low -> halt_req=0.
6. With FPGA_CLKRST_MCS4_CLK_STOP_EN: assert mcs4_clk_stop while mclk=1 -> clock falls at its scheduled edge and stays 0; deassert -> rises 34 cycles later.

Source files
------------

// File: rtl/fpga_clkrst_ctrl.sv
// Clock/reset controller: power-on reset, synchronized system reset, halt strap sync,
// MCS-4 clock divider and MCS-4 reset sequencer. Optional clock freeze: FPGA_CLKRST_MCS4_CLK_STOP_EN.
module fpga_clkrst_ctrl #(
   parameter int unsigned POR_CYCLES   = 1024,
   parameter int unsigned MCS4_HALF    = 34,
   parameter int unsigned MCS4_RES_CYC = 64
) (
   input  logic CLK50,
   input  logic RES_N,
   input  logic RESET_HALT_N,
   input  logic MCS4_RES_REQ,
`ifdef FPGA_CLKRST_MCS4_CLK_STOP_EN
   input  logic mcs4_clk_stop,
`endif
   output logic clk,
   output logic res_sys_n,
   output logic RESOUT_N,
   output logic halt_req,
   output logic S_MCS4_CLK,
   output logic S_MCS4_RES_N
);

   localparam logic [15:0] POR_LAST  = 16'(POR_CYCLES - 32'd1);
   localparam logic [7:0]  HALF_LAST = 8'(MCS4_HALF - 32'd1);
   localparam logic [7:0]  RES_LAST  = 8'(MCS4_RES_CYC - 32'd1);
   localparam logic [7:0]  RES_DONE  = 8'(MCS4_RES_CYC);

   // Power-on state starts from the configuration image, never from RES_N.
   logic [15:0] por_count_q = 16'd0;
   logic        por_n_q     = 1'b0;
   logic        arst_n_s;
   logic        sys_rst_n_s;
   logic [1:0]  rst_sync_q;
   logic        halt_meta_q;
   logic        halt_req_q;
   logic        stop_s;
   logic        fall_s;
   logic [7:0]  div_cnt_q, div_cnt_d;
   logic        mclk_q, mclk_d;
   logic [7:0]  mres_cnt_q, mres_cnt_d;
   logic        mres_n_q, mres_n_d;

`ifdef FPGA_CLKRST_MCS4_CLK_STOP_EN
   assign stop_s = mcs4_clk_stop;
`else
   assign stop_s = 1'b0;
`endif

   // Power-on counter: runs once after configuration, then freezes.
   always_ff @(posedge CLK50) begin
      if (!por_n_q) begin
         por_count_q <= por_count_q + 16'd1;
         if (por_count_q == POR_LAST) begin
            por_n_q <= 1'b1;
         end
      end
   end

   assign arst_n_s    = RES_N & por_n_q;
   assign sys_rst_n_s = rst_sync_q[1];

   // System reset synchronizer: asserts asynchronously, releases on the second edge.
   always_ff @(posedge CLK50 or negedge arst_n_s) begin
      if (!arst_n_s) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   // Halt strap synchronizer; the second stage stores the inverted level directly.
   always_ff @(posedge CLK50 or negedge sys_rst_n_s) begin
      if (!sys_rst_n_s) begin
         halt_meta_q <= 1'b1;
         halt_req_q  <= 1'b0;
      end else begin
         halt_meta_q <= RESET_HALT_N;
         halt_req_q  <= ~halt_meta_q;
      end
   end

   // A frozen clock only blocks the rising toggle; a pending fall still completes.
   assign fall_s = (div_cnt_q == HALF_LAST) && mclk_q;

   // Divider and MCS-4 reset sequencer next state.
   always_comb begin
      div_cnt_d  = div_cnt_q;
      mclk_d     = mclk_q;
      mres_cnt_d = mres_cnt_q;
      mres_n_d   = mres_n_q;
      if (stop_s && !mclk_q) begin
         div_cnt_d = 8'd0;
         mclk_d    = 1'b0;
      end else if (div_cnt_q == HALF_LAST) begin
         div_cnt_d = 8'd0;
         mclk_d    = ~mclk_q;
      end else begin
         div_cnt_d = div_cnt_q + 8'd1;
      end
      // The request outranks a release falling on the same edge.
      if (MCS4_RES_REQ) begin
         mres_cnt_d = 8'd0;
         mres_n_d   = 1'b0;
      end else if (!mres_n_q && fall_s) begin
         if (mres_cnt_q == RES_LAST) begin
            mres_cnt_d = RES_DONE;
            mres_n_d   = 1'b1;
         end else begin
            mres_cnt_d = mres_cnt_q + 8'd1;
         end
      end else begin
         mres_cnt_d = mres_cnt_q;
      end
   end

   // MCS-4 state registers, cleared with the system reset.
   always_ff @(posedge CLK50 or negedge sys_rst_n_s) begin
      if (!sys_rst_n_s) begin
         div_cnt_q  <= 8'd0;
         mclk_q     <= 1'b0;
         mres_cnt_q <= 8'd0;
         mres_n_q   <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         mclk_q     <= mclk_d;
         mres_cnt_q <= mres_cnt_d;
         mres_n_q   <= mres_n_d;
      end
   end

   assign clk          = CLK50;
   assign res_sys_n    = sys_rst_n_s;
   assign RESOUT_N     = sys_rst_n_s;
   assign halt_req     = halt_req_q;
   assign S_MCS4_CLK   = mclk_q;
   assign S_MCS4_RES_N = mres_n_q;

endmodule

// File: tb/tb_fpga_clkrst_ctrl.sv
// Directed bench for fpga_clkrst_ctrl; edge numbers count CLK50 posedges from time zero.
module tb_fpga_clkrst_ctrl;

   logic CLK50        = 1'b0;
   logic RES_N        = 1'b0;
   logic RESET_HALT_N = 1'b1;
   logic MCS4_RES_REQ = 1'b0;
`ifdef FPGA_CLKRST_MCS4_CLK_STOP_EN
   logic mcs4_clk_stop = 1'b0;
`endif
   logic clk, res_sys_n, RESOUT_N, halt_req, S_MCS4_CLK, S_MCS4_RES_N;

   int e      = 0;
   int n_cmp  = 0;
   int n_err  = 0;
   int at;
   int por_at = -1;
   int rs_at  = -1;

   fpga_clkrst_ctrl #(
      .POR_CYCLES  (16),
      .MCS4_HALF   (34),
      .MCS4_RES_CYC(64)
   ) dut (
      .CLK50        (CLK50),
      .RES_N        (RES_N),
      .RESET_HALT_N (RESET_HALT_N),
      .MCS4_RES_REQ (MCS4_RES_REQ),
`ifdef FPGA_CLKRST_MCS4_CLK_STOP_EN
      .mcs4_clk_stop(mcs4_clk_stop),
`endif
      .clk          (clk),
      .res_sys_n    (res_sys_n),
      .RESOUT_N     (RESOUT_N),
      .halt_req     (halt_req),
      .S_MCS4_CLK   (S_MCS4_CLK),
      .S_MCS4_RES_N (S_MCS4_RES_N)
   );

   always #10 CLK50 = ~CLK50;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, exp, e);
      end
   endtask

   task automatic step();
      @(posedge CLK50);
      #1;
      e = e + 1;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return res_sys_n;
         1:       return S_MCS4_CLK;
         2:       return S_MCS4_RES_N;
         default: return halt_req;
      endcase
   endfunction

   task automatic wait_lvl(input int sel, input logic lvl, input int bound, output int t);
      t = -1;
      for (int i = 0; i < bound; i++) begin
         step();
         if (sig(sel) == lvl) begin
            t = e;
            break;
         end
      end
   endtask

   initial begin
      #1;
      check_eq("rst_res_sys_n", int'(res_sys_n), 0);
      check_eq("rst_resout_n", int'(RESOUT_N), 0);
      check_eq("rst_halt_req", int'(halt_req), 0);
      check_eq("rst_mclk", int'(S_MCS4_CLK), 0);
      check_eq("rst_mres_n", int'(S_MCS4_RES_N), 0);
      #1;
      RES_N = 1'b1;

      // Power-on: por_n at edge 16, system reset release at edge 18
      for (int i = 0; i < 20; i++) begin
         step();
         if (dut.por_n_q && por_at < 0) por_at = e;
         if (res_sys_n && rs_at < 0) rs_at = e;
      end
      check_eq("por_rise", por_at, 16);
      check_eq("res_sys_rise", rs_at, 18);
      check_eq("resout_n", int'(RESOUT_N), 1);
      check_eq("clk_pass", int'(clk), int'(CLK50));

      // MCS-4 clock: rise 52, fall 86, rise 120
      wait_lvl(1, 1'b1, 200, at);
      check_eq("mclk_first_rise", at, 52);
      wait_lvl(1, 1'b0, 200, at);
      check_eq("mclk_first_fall", at, 86);
      wait_lvl(1, 1'b1, 200, at);
      check_eq("mclk_second_rise", at, 120);

      // MCS-4 reset release on the 64th falling edge: 18 + 64*68
      wait_lvl(2, 1'b1, 5000, at);
      check_eq("mres_release", at, 4370);
      check_eq("mclk_low_at_release", int'(S_MCS4_CLK), 0);

      // Halt strap, two-cycle latency
      RESET_HALT_N = 1'b0;
      step();
      check_eq("halt_lat1", int'(halt_req), 0);
      step();
      check_eq("halt_lat2", int'(halt_req), 1);

      // One-cycle request re-resets the MCS-4
      MCS4_RES_REQ = 1'b1;
      step();
      check_eq("req_mres_low", int'(S_MCS4_RES_N), 0);
      MCS4_RES_REQ = 1'b0;
      while (e < 8721) step();
      check_eq("req_still_low", int'(S_MCS4_RES_N), 0);

      // Request landing on the release edge (8722) keeps reset low
      MCS4_RES_REQ = 1'b1;
      step();
      check_eq("req_wins_release", int'(S_MCS4_RES_N), 0);
      MCS4_RES_REQ = 1'b0;
      wait_lvl(2, 1'b1, 5000, at);
      check_eq("mres_release2", at, 13074);

      // RES_N pulse while mclk is high clears everything asynchronously
      while (e < 13120) step();
      check_eq("mclk_high_pre", int'(S_MCS4_CLK), 1);
      RES_N = 1'b0;
      #2;
      check_eq("async_res_sys_n", int'(res_sys_n), 0);
      check_eq("async_resout_n", int'(RESOUT_N), 0);
      check_eq("async_mclk", int'(S_MCS4_CLK), 0);
      check_eq("async_mres_n", int'(S_MCS4_RES_N), 0);
      check_eq("async_halt_req", int'(halt_req), 0);
      repeat (10) step();
      RES_N = 1'b1;
      step();
      check_eq("rel_res_sys_1", int'(res_sys_n), 0);
      step();
      check_eq("rel_res_sys_2", int'(res_sys_n), 1);
      check_eq("rel_halt_0", int'(halt_req), 0);
      step();
      step();
      check_eq("rel_halt_1", int'(halt_req), 1);
      wait_lvl(1, 1'b1, 200, at);
      check_eq("mclk_rise_after_rst", at, 13166);

`ifdef FPGA_CLKRST_MCS4_CLK_STOP_EN
      // Freeze while high: falls on schedule at 13200, stays low, restarts 34 later
      mcs4_clk_stop = 1'b1;
      wait_lvl(1, 1'b0, 100, at);
      check_eq("stop_fall", at, 13200);
      repeat (100) step();
      check_eq("stop_frozen", int'(S_MCS4_CLK), 0);
      mcs4_clk_stop = 1'b0;
      wait_lvl(1, 1'b1, 100, at);
      check_eq("stop_release_rise", at, 13334);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
